// File: rtl/writeback_retire_buffer.sv
// Writeback stage: an in-order retire queue that waits on in-order load responses,
// formats load data and retires one instruction per cycle into an internal register
// file. Define WRITEBACK_BYPASS_EN to forward the retiring value to the read ports.
module writeback_retire_buffer #(
  parameter int XLEN           = 32,
  parameter int DEPTH          = 4,
  parameter int NUM_READ_PORTS = 2,
  parameter int REG_COUNT      = 32,
  localparam int TW            = $clog2(REG_COUNT),
  localparam int CW            = $clog2(DEPTH) + 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [TW-1:0]                  in_rd,
  input  logic [1:0]                     in_kind,
  input  logic [2:0]                     in_load_type,
  input  logic [XLEN-1:0]                in_result,
  input  logic [XLEN-1:0]                in_link,
  input  logic                           mem_rsp_valid,
  input  logic [XLEN-1:0]                mem_rsp_data,
  input  logic [NUM_READ_PORTS*TW-1:0]   rd_tag,
  output logic [NUM_READ_PORTS*XLEN-1:0] rd_data,
  output logic                           wb_valid,
  output logic [TW-1:0]                  wb_rd,
  output logic [XLEN-1:0]                wb_data,
  output logic [CW-1:0]                  loads_pending,
  output logic                           err_unexpected_rsp
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(XLEN / 8);

  typedef enum logic [1:0] {
    KIND_ALU  = 2'b00,
    KIND_LOAD = 2'b01,
    KIND_LINK = 2'b10,
    KIND_NONE = 2'b11
  } kind_e;

  typedef struct packed {
    kind_e           kind;
    logic [TW-1:0]   rd;
    logic [2:0]      load_type;
    logic [OW-1:0]   off;
    logic [XLEN-1:0] value;
  } entry_t;

  entry_t          q [DEPTH];
  logic [DEPTH-1:0] waiting;
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;
  logic [CW-1:0]   pending;
  logic            err_q;
  logic [XLEN-1:0] regs [REG_COUNT];

  kind_e           in_kind_e;
  logic            push;
  logic            push_load;
  logic            head_ready;
  logic            retire;
  logic            cap_hit;
  logic [PW-1:0]   cap_idx;
  logic            capture;

  // Select the addressed byte/half/word from the aligned memory word and extend it.
  function automatic logic [XLEN-1:0] format_load(input logic [XLEN-1:0] data,
                                                  input logic [2:0]      load_type,
                                                  input logic [OW-1:0]   off);
    logic [OW-1:0]   base;
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] mask;
    logic            sign;
    case (load_type[1:0])
      2'b00:   base = off;
      2'b01:   base = off & ~OW'(1);
      2'b10:   base = off & ~OW'(3);
      default: base = (XLEN == 64) ? '0 : (off & ~OW'(3));
    endcase
    sh = data >> {base, 3'b000};
    case (load_type[1:0])
      2'b00: begin
        mask = XLEN'(8'hFF);
        sign = sh[7];
      end
      2'b01: begin
        mask = XLEN'(16'hFFFF);
        sign = sh[15];
      end
      2'b10: begin
        mask = XLEN'(32'hFFFF_FFFF);
        sign = sh[31];
      end
      default: begin
        if (XLEN == 64) begin
          mask = '1;
          sign = 1'b0;
        end else begin
          mask = XLEN'(32'hFFFF_FFFF);
          sign = sh[31];
        end
      end
    endcase
    return (sh & mask) | ((~load_type[2] & sign) ? ~mask : '0);
  endfunction

  assign in_kind_e = kind_e'(in_kind);
  assign in_ready  = (count < CW'(DEPTH));
  assign push      = in_valid && in_ready;
  assign push_load = push && (in_kind_e == KIND_LOAD);

  // NOTE: every variable written here gets a default first, so no path infers a latch.
  always_comb begin
    cap_hit = 1'b0;
    cap_idx = head;
    for (int i = 0; i < DEPTH; i++) begin
      if (!cap_hit && (CW'(i) < count) && waiting[head + PW'(i)]) begin
        cap_hit = 1'b1;
        cap_idx = head + PW'(i);
      end
    end
  end

  assign capture    = mem_rsp_valid && cap_hit;
  assign head_ready = (count != '0) && ((q[head].kind != KIND_LOAD) || !waiting[head]);
  assign retire     = head_ready;

  assign wb_valid = head_ready && (q[head].kind != KIND_NONE) && (q[head].rd != '0);
  assign wb_rd    = wb_valid ? q[head].rd    : '0;
  assign wb_data  = wb_valid ? q[head].value : '0;

  assign loads_pending      = pending;
  assign err_unexpected_rsp = err_q;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      pending <= '0;
      waiting <= '0;
      err_q   <= 1'b0;
    end else begin
      if (push)   tail <= tail + 1'b1;
      if (retire) head <= head + 1'b1;
      count   <= count + CW'(push) - CW'(retire);
      pending <= pending + CW'(push_load) - CW'(capture);
      // A push targets a free slot and a capture a live one, so these never collide.
      if (push)    waiting[tail]    <= push_load;
      if (capture) waiting[cap_idx] <= 1'b0;
      if (mem_rsp_valid && (pending == '0)) err_q <= 1'b1;
    end
  end

  // NOTE: queue payload is deliberately not reset; count and the waiting flags decide what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      q[tail] <= '{kind:      in_kind_e,
                   rd:        in_rd,
                   load_type: in_load_type,
                   off:       in_result[OW-1:0],
                   value:     (in_kind_e == KIND_LINK) ? in_link : in_result};
    end
    if (capture) begin
      q[cap_idx].value <= format_load(mem_rsp_data, q[cap_idx].load_type, q[cap_idx].off);
    end
  end

  // Register 0 is never written because wb_valid excludes rd = 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < REG_COUNT; r++) regs[r] <= '0;
    end else if (wb_valid) begin
      regs[wb_rd] <= wb_data;
    end
  end

  for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_read
    logic [TW-1:0]   tag;
    logic [XLEN-1:0] data;

    assign tag = rd_tag[p*TW +: TW];

    always_comb begin
      data = '0;
      if (tag != '0) data = regs[tag];
`ifdef WRITEBACK_BYPASS_EN
      if (wb_valid && (tag == wb_rd)) data = wb_data;
`endif
    end

    assign rd_data[p*XLEN +: XLEN] = data;
  end

endmodule
